i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/i2s_tx.sv | 138 +++++++++++++
 tb/tb_i2s_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// I2S slave transmitter: bit clock and word select come from an external master
// and are oversampled in the clk_i domain; each word is shifted out MSB first.
module i2s_tx #(
   parameter int WORD_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [WORD_WIDTH-1:0] data_i,
   output logic                  lr_chnl_o,
   output logic                  write_o,
   input  logic                  sclk_i,
   input  logic                  wsel_i,
   output logic                  sdat_o
);

   localparam int               CNT_W    = $clog2(WORD_WIDTH);
   localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(WORD_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   logic                  rst_meta_r;
   logic                  rst_sync_r;

   logic                  sclk_meta_r;
   logic                  sclk_sync_r;
   logic                  sclk_prev_r;
   logic                  ws_meta_r;
   logic                  ws_sync_r;

   logic                  ws_cur_r;
   logic                  ws_prev_r;
   logic [WORD_WIDTH-1:0] shreg_r;
   logic [CNT_W-1:0]      cnt_r;
   logic                  sdat_r;
   logic                  write_r;
   logic                  lr_r;

   logic                  bit_stb_s;
   logic                  load_s;
   logic                  ws_cur_nxt_s;
   logic                  ws_prev_nxt_s;
   logic [WORD_WIDTH-1:0] shreg_nxt_s;
   logic [CNT_W-1:0]      cnt_nxt_s;
   logic                  sdat_nxt_s;
   logic                  write_nxt_s;
   logic                  lr_nxt_s;

   // Reset synchroniser: asserts asynchronously, releases on a clk_i edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rst_meta_r <= 1'b0;
         rst_sync_r <= 1'b0;
      end else begin
         rst_meta_r <= 1'b1;
         rst_sync_r <= rst_meta_r;
      end
   end

   // Two-flop synchronisers for sclk and wsel, plus sclk history for edge detection.
   always_ff @(posedge clk_i or negedge rst_sync_r) begin
      if (!rst_sync_r) begin
         sclk_meta_r <= 1'b0;
         sclk_sync_r <= 1'b0;
         sclk_prev_r <= 1'b0;
         ws_meta_r   <= 1'b0;
         ws_sync_r   <= 1'b0;
      end else begin
         sclk_meta_r <= sclk_i;
         sclk_sync_r <= sclk_meta_r;
         sclk_prev_r <= sclk_sync_r;
         ws_meta_r   <= wsel_i;
         ws_sync_r   <= ws_meta_r;
      end
   end

   // Only falling sclk edges advance the transmitter.
   assign bit_stb_s = sclk_prev_r & ~sclk_sync_r;
   // ws_cur/ws_prev hold the last two sampled word selects, so a mismatch means
   // the previous falling edge saw a WS change: this edge starts the new word.
   assign load_s    = bit_stb_s & (ws_cur_r ^ ws_prev_r);

   // Next-state decode for the shifter, bit counter and registered outputs.
   always_comb begin
      ws_cur_nxt_s  = ws_cur_r;
      ws_prev_nxt_s = ws_prev_r;
      shreg_nxt_s   = shreg_r;
      cnt_nxt_s     = cnt_r;
      sdat_nxt_s    = sdat_r;
      write_nxt_s   = 1'b0;
      lr_nxt_s      = lr_r;
      if (bit_stb_s) begin
         ws_cur_nxt_s  = ws_sync_r;
         ws_prev_nxt_s = ws_cur_r;
         if (load_s) begin
            shreg_nxt_s = data_i;
            sdat_nxt_s  = data_i[WORD_WIDTH-1];
            write_nxt_s = 1'b1;
            lr_nxt_s    = ws_cur_r;
            cnt_nxt_s   = CNT_TOP;
         end else if (cnt_r != CNT_ZERO) begin
            shreg_nxt_s = shreg_r << 1;
            sdat_nxt_s  = shreg_r[WORD_WIDTH-2];
            cnt_nxt_s   = cnt_r - CNT_ONE;
         end else begin
            sdat_nxt_s = 1'b0;
            cnt_nxt_s  = CNT_ZERO;
         end
      end else begin
         write_nxt_s = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_sync_r) begin
      if (!rst_sync_r) begin
         ws_cur_r  <= 1'b0;
         ws_prev_r <= 1'b0;
         shreg_r   <= {WORD_WIDTH{1'b0}};
         cnt_r     <= CNT_ZERO;
         sdat_r    <= 1'b0;
         write_r   <= 1'b0;
         lr_r      <= 1'b0;
      end else begin
         ws_cur_r  <= ws_cur_nxt_s;
         ws_prev_r <= ws_prev_nxt_s;
         shreg_r   <= shreg_nxt_s;
         cnt_r     <= cnt_nxt_s;
         sdat_r    <= sdat_nxt_s;
         write_r   <= write_nxt_s;
         lr_r      <= lr_nxt_s;
      end
   end

   assign sdat_o    = sdat_r;
   assign write_o   = write_r;
   assign lr_chnl_o = lr_r;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: acts as I2S master and receiver, models the expected serial
// stream per bit slot, and feeds words upstream on every write_o strobe.
`timescale 1ns/1ps
module tb_i2s_tx;

   localparam int W = 16;

   logic         clk_i;
   logic         rst_ni;
   logic [W-1:0] data_i;
   logic         lr_chnl_o;
   logic         write_o;
   logic         sclk_i;
   logic         wsel_i;
   logic         sdat_o;

   i2s_tx #(.WORD_WIDTH(W)) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .data_i    (data_i),
      .lr_chnl_o (lr_chnl_o),
      .write_o   (write_o),
      .sclk_i    (sclk_i),
      .wsel_i    (wsel_i),
      .sdat_o    (sdat_o)
   );

   // 80 MHz system clock
   initial begin
      clk_i = 1'b0;
      forever #6.25 clk_i = ~clk_i;
   end

   logic [W-1:0] words [0:63];
   int           vec;
   int           errs;
   int           nload;
   int           wr_total;
   int           wr_seen;
   int           upd_cnt;
   int           pos;
   int           exp_wr;
   int           rx_len;
   int           snap_len [0:1];
   logic [31:0]  rx_acc;
   logic [31:0]  snap_word [0:1];
   logic [W-1:0] cur_word;
   bit           w1, w2, m_active, m_lr;
   bit           exp_sdat, exp_lr, exp_load, chk_en;
   bit           rx_active, rx_ch, write_prev;

   // Upstream source and per-cycle checks: reset outputs, single-cycle write_o.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         vec++;
         if (sdat_o !== 1'b0 || write_o !== 1'b0 || lr_chnl_o !== 1'b0) begin
            errs++;
            $display("FAIL reset_outputs: sdat=%b write=%b lr=%b, required 0 0 0",
                     sdat_o, write_o, lr_chnl_o);
         end
         if (wr_total == 0) data_i = words[0];
      end
      if (write_o === 1'b1) begin
         vec++;
         if (write_prev) begin
            errs++;
            $display("FAIL write_width: write_o high on two consecutive cycles at %0t", $time);
         end
         wr_seen++;
         wr_total++;
         upd_cnt = 3;
      end else if (upd_cnt > 0) begin
         upd_cnt--;
         if (upd_cnt == 2) data_i = W'($urandom);
         else if (upd_cnt == 0) data_i = words[wr_total];
      end
      write_prev = (write_o === 1'b1);
   end

   // Receiver and slot compare on every rising sclk edge.
   always @(posedge sclk_i) begin
      if (chk_en) begin
         vec++;
         if (sdat_o !== exp_sdat) begin
            errs++;
            $display("FAIL sdat_bit: got %b, required %b at %0t", sdat_o, exp_sdat, $time);
         end
         vec++;
         if (lr_chnl_o !== exp_lr) begin
            errs++;
            $display("FAIL lr_chnl: got %b, required %b at %0t", lr_chnl_o, exp_lr, $time);
         end
         vec++;
         if (wr_seen != exp_wr) begin
            errs++;
            $display("FAIL write_count: got %0d pulses, required %0d at %0t", wr_seen, exp_wr, $time);
         end
         wr_seen = 0;
         if (exp_load) begin
            if (rx_active) begin
               snap_word[rx_ch] = rx_acc;
               snap_len[rx_ch]  = rx_len;
            end
            rx_acc    = 32'h0;
            rx_len    = 0;
            rx_active = 1'b1;
            rx_ch     = exp_lr;
         end
         if (rx_active && rx_len < 32) begin
            rx_acc = {rx_acc[30:0], sdat_o};
            rx_len++;
         end
      end
   end

   // One sclk period with wsel = ch; the model decides the bit the DUT must send.
   task automatic slot(input bit ch);
      sclk_i   = 1'b0;
      wsel_i   = ch;
      exp_load = (w1 != w2);
      if (exp_load) begin
         cur_word = words[nload];
         nload++;
         pos      = 0;
         m_active = 1'b1;
         m_lr     = w1;
      end
      exp_wr   = exp_load ? 1 : 0;
      exp_sdat = (m_active && pos < W) ? cur_word[W-1-pos] : 1'b0;
      if (m_active && pos < W) pos++;
      exp_lr = m_lr;
      w2     = w1;
      w1     = ch;
      #50 sclk_i = 1'b1;
      #50;
   endtask

   task automatic frame(input bit ch, input int n);
      repeat (n) slot(ch);
   endtask

   task automatic check_snap(input bit ch, input logic [31:0] word, input int len, input string name);
      vec++;
      if (snap_word[ch] !== word || snap_len[ch] != len) begin
         errs++;
         $display("FAIL %s: received %h (%0d bits), required %h (%0d bits)",
                  name, snap_word[ch], snap_len[ch], word, len);
      end
   endtask

   // Reset pulse of 50 ns while sclk idles high; the model returns to reset state.
   task automatic pulse_reset();
      #10 rst_ni = 1'b0;
      w1        = 1'b0;
      w2        = 1'b0;
      m_active  = 1'b0;
      m_lr      = 1'b0;
      pos       = 0;
      rx_active = 1'b0;
      #50 rst_ni = 1'b1;
      #90;
   endtask

   initial begin
      rst_ni = 1'b0;
      sclk_i = 1'b1;
      wsel_i = 1'b0;
      chk_en = 1'b0;
      for (int i = 0; i < 64; i++) words[i] = W'($urandom);
      words[0] = 16'h0F0F;
      words[1] = 16'hA5C3;
      words[2] = 16'h1234;
      words[4] = 16'hFFFF;
      words[5] = 16'hFFFF;
      words[6] = 16'hFF00;
      #103 rst_ni = 1'b1;
      #100 chk_en = 1'b1;

      // stereo frames of exactly 16 bits
      frame(1'b1, 4);
      frame(1'b0, 16);
      frame(1'b1, 16);
      frame(1'b0, 16);
      check_snap(1'b0, 32'h0000A5C3, 16, "left_word_a5c3");
      check_snap(1'b1, 32'h00001234, 16, "right_word_1234");

      // 24-bit WS periods pad with zeros
      frame(1'b1, 24);
      frame(1'b0, 24);
      frame(1'b1, 8);
      check_snap(1'b1, 32'h00FFFF00, 24, "right_padded_ffff");
      check_snap(1'b0, 32'h00FFFF00, 24, "left_padded_ffff");

      // WS toggles after 8 bits: the word is cut short
      frame(1'b0, 16);
      check_snap(1'b1, 32'h000000FF, 8, "aborted_ff00");

      // reset in the middle of a word
      frame(1'b1, 6);
      pulse_reset();
      frame(1'b1, 5);
      vec++;
      if (wr_total != 10) begin
         errs++;
         $display("FAIL writes_after_reset: got %0d write_o pulses, required 10", wr_total);
      end

      // randomised frame lengths, including early WS changes
      for (int f = 0; f < 22; f++) frame(f[0] ? 1'b0 : 1'b1, $urandom_range(3, 26));
      frame(1'b0, 4);

      vec++;
      if (wr_total != nload) begin
         errs++;
         $display("FAIL total_writes: got %0d write_o pulses, required %0d", wr_total, nload);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
